shared_serpar_buf: RTL and testbench
====================================

SHARED_SERPAR_BUF -- requirements
Module: shared_serpar_buf

Interface
REQ-001 Parameter W_BLK, default 128: block width in bits; SHALL be a multiple of 8.
REQ-002 Parameter N_ST, default 2: number of state-share blocks (one per share); SHALL be >= 1.
REQ-003 Parameter N_TK, default 5: number of tweakey-share blocks; SHALL be >= 1.
REQ-004 Derived: TOT = W_BLK*(N_ST+N_TK), NBYTES = TOT/8, OUT_BYTES = N_ST*W_BLK/8, ST_LO = N_TK*W_BLK; cnt width = clog2(NBYTES+1).
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 in_data  in  8  serial load byte.
REQ-008 in_valid  in  1  in_data valid.
REQ-009 in_ready  out  1  buffer accepts a byte this cycle.
REQ-010 out_data  out  8  serial unload byte, always bfr[TOT-1:TOT-8].
REQ-011 out_valid  out  1  out_data valid.
REQ-012 out_ready  in  1  downstream accepts out_data.
REQ-013 data_core  in  TOT  parallel result from cipher core.
REQ-014 cap_st  in  1  capture state-share blocks from data_core.
REQ-015 cap_tk  in  1  capture tweakey-share blocks from data_core.
REQ-016 start_rd  in  1  begin serial unload.
REQ-017 clr  in  1  synchronous abort/clear.
REQ-018 bfr  out  TOT  parallel buffer contents to core.
REQ-019 full  out  1  high in state FULL.

Function
REQ-020 FSM states EMPTY, FULL, UNLOAD; in_ready = (state==EMPTY); out_valid = (state==UNLOAD); full = (state==FULL); all three decoded from registered state only.
REQ-021 EMPTY: on in_valid&in_ready, bfr <= {bfr[TOT-9:0], in_data}, cnt <= cnt+1; no change when in_valid=0.
REQ-022 EMPTY: acceptance of byte with cnt==NBYTES-1 SHALL move to FULL with cnt <= 0; first loaded byte ends at bfr[TOT-1:TOT-8].
REQ-023 FULL: cap_st SHALL load bfr[TOT-1:ST_LO] <= data_core[TOT-1:ST_LO]; cap_tk SHALL load bfr[ST_LO-1:0] <= data_core[ST_LO-1:0]; both together load both fields; state stays FULL.
REQ-024 FULL: start_rd with cap_st=cap_tk=0 SHALL move to UNLOAD, cnt <= 0; start_rd in same cycle as any capture SHALL be ignored (capture wins).
REQ-025 UNLOAD: on out_valid&out_ready, bfr <= {bfr[TOT-9:0], 8'h00}, cnt <= cnt+1; no change when out_ready=0; out_data stable while stalled.
REQ-026 UNLOAD: handshake with cnt==OUT_BYTES-1 SHALL move to EMPTY, cnt <= 0; exactly OUT_BYTES bytes emitted, MSB byte first.
REQ-027 cap_st, cap_tk, start_rd SHALL be ignored outside FULL; in_valid ignored outside EMPTY.
REQ-028 clr SHALL have priority over all other inputs: state <= EMPTY, cnt <= 0, bfr <= 0 on the next edge, in any state.
REQ-029 Latency: full asserts the cycle after the NBYTES-th accept; out_valid asserts the cycle after accepted start_rd; in_ready asserts the cycle after the last unload handshake.
REQ-030 Back-to-back: load may begin the cycle in_ready reasserts; no bubble beyond REQ-029.

Reset
REQ-031 rst high SHALL immediately force state EMPTY, cnt 0, bfr 0, out_valid 0, full 0, independent of clk.
REQ-032 While rst high, in_valid SHALL not alter bfr or cnt; first accept occurs on first rising edge with rst low.

Verification (defaults: TOT=896, NBYTES=112, OUT_BYTES=32)
REQ-033 Reset, stream bytes 0x00..0x6F with in_valid=1 -> full=1 one cycle after 112th accept, bfr[895:888]=0x00, bfr[7:0]=0x6F, in_ready=0.
REQ-034 Same stream with random in_valid gaps -> identical bfr; cnt frozen on gap cycles.
REQ-035 In FULL, data_core=A, cap_st=cap_tk=1 with start_rd=1 -> bfr={A[895:640],A[639:0]}, state stays FULL; repeat with cap_tk only -> bfr[895:640] unchanged.
REQ-036 start_rd, out_ready toggling 1/0 -> exactly 32 handshakes, bytes = bfr[895:640] MSB first, then EMPTY, in_ready=1, out_valid=0.
REQ-037 clr after 50 loaded bytes -> bfr=0, cnt=0, next full only after 112 fresh bytes; clr mid-UNLOAD -> out_valid=0 next cycle.
REQ-038 rst asserted between edges during UNLOAD -> out_valid, full, bfr zero without a clock edge.

Source files
------------

// File: rtl/shared_serpar_buf.sv
// shared_serpar_buf: byte-serial load / parallel capture / byte-serial unload buffer for a shared cipher state
// Ports: clk, rst (async, active-high); in_data/in_valid/in_ready load byte stream;
// out_data/out_valid/out_ready unload byte stream; data_core, cap_st, cap_tk parallel capture;
// start_rd begins unload; clr synchronous abort; bfr parallel contents; full high while loaded.
module shared_serpar_buf #(
    parameter int W_BLK = 128,
    parameter int N_ST  = 2,
    parameter int N_TK  = 5
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [7:0]                     in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [7:0]                     out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    input  logic [W_BLK*(N_ST+N_TK)-1:0]   data_core,
    input  logic                           cap_st,
    input  logic                           cap_tk,
    input  logic                           start_rd,
    input  logic                           clr,
    output logic [W_BLK*(N_ST+N_TK)-1:0]   bfr,
    output logic                           full
);
    localparam int TOT       = W_BLK * (N_ST + N_TK);
    localparam int NBYTES    = TOT / 8;
    localparam int OUT_BYTES = N_ST * W_BLK / 8;
    localparam int ST_LO     = N_TK * W_BLK;
    localparam int CW        = $clog2(NBYTES + 1);

    typedef enum logic [1:0] {EMPTY, FULL, UNLOAD} state_t;

    state_t         state, state_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [TOT-1:0] bfr_n;

    assign in_ready  = state == EMPTY;
    assign out_valid = state == UNLOAD;
    assign full      = state == FULL;
    assign out_data  = bfr[TOT-1 -: 8];

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bfr_n   = bfr;
        if (clr) begin
            state_n = EMPTY;
            cnt_n   = '0;
            bfr_n   = '0;
        end else begin
            case (state)
                EMPTY: if (in_valid) begin
                    bfr_n   = {bfr[TOT-9:0], in_data};
                    cnt_n   = cnt == CW'(NBYTES - 1) ? '0 : cnt + CW'(1);
                    state_n = cnt == CW'(NBYTES - 1) ? FULL : EMPTY;
                end
                FULL: begin
                    if (cap_st) bfr_n[TOT-1:ST_LO] = data_core[TOT-1:ST_LO];
                    if (cap_tk) bfr_n[ST_LO-1:0] = data_core[ST_LO-1:0];
                    // a capture in the same cycle suppresses the unload request
                    if (start_rd && !cap_st && !cap_tk) begin
                        state_n = UNLOAD;
                        cnt_n   = '0;
                    end
                end
                UNLOAD: if (out_ready) begin
                    bfr_n   = {bfr[TOT-9:0], 8'h00};
                    cnt_n   = cnt == CW'(OUT_BYTES - 1) ? '0 : cnt + CW'(1);
                    state_n = cnt == CW'(OUT_BYTES - 1) ? EMPTY : UNLOAD;
                end
                default: begin
                    state_n = EMPTY;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
            cnt   <= '0;
            bfr   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            bfr   <= bfr_n;
        end
    end
endmodule

// File: tb/tb_shared_serpar_buf.sv
// tb_shared_serpar_buf: self-checking bench for shared_serpar_buf with a reference buffer model and unload byte queue
module tb_shared_serpar_buf;
    localparam int W_BLK     = 128;
    localparam int N_ST      = 2;
    localparam int N_TK      = 5;
    localparam int TOT       = W_BLK * (N_ST + N_TK);
    localparam int NBYTES    = TOT / 8;
    localparam int OUT_BYTES = N_ST * W_BLK / 8;
    localparam int ST_LO     = N_TK * W_BLK;

    logic           clk, rst;
    logic [7:0]     in_data, out_data;
    logic           in_valid, in_ready, out_valid, out_ready;
    logic [TOT-1:0] data_core, bfr;
    logic           cap_st, cap_tk, start_rd, clr, full;
    logic [TOT-1:0] mdl;
    int             checks, errors;

    shared_serpar_buf #(.W_BLK(W_BLK), .N_ST(N_ST), .N_TK(N_TK)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .data_core(data_core), .cap_st(cap_st), .cap_tk(cap_tk),
        .start_rd(start_rd), .clr(clr), .bfr(bfr), .full(full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [TOT-1:0] rnd_blk();
        logic [TOT-1:0] v;
        for (int i = 0; i < TOT / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        in_valid = 1'b1;
        in_data  = 8'hAA;
        #1;
        checks++; if (bfr !== '0 || full !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL reset_state: bfr_nonzero=%0b full=%b out_valid=%b in_ready=%b, want 0 0 0 1", bfr != '0, full, out_valid, in_ready); end
        repeat (2) step();
        checks++; if (bfr !== '0) begin errors++; $display("FAIL reset_holds_bfr: got %h want 0", bfr[TOT-1 -: 32]); end
        in_valid = 1'b0;
        rst      = 1'b0;
    endtask

    task automatic do_load(input int n, input bit gaps);
        int k   = 0;
        int cyc = 0;
        while (k < n && cyc < 4 * NBYTES) begin
            in_data  = 8'(k);
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            if (in_valid) begin
                mdl = {mdl[TOT-9:0], 8'(k)};
                k++;
            end
            checks++; if (bfr !== mdl) begin errors++; $display("FAIL load_bfr byte %0d: got %h want %h", k, bfr[31:0], mdl[31:0]); end
            checks++; if (full !== (k == NBYTES)) begin errors++; $display("FAIL load_full after %0d bytes: got %b want %b", k, full, k == NBYTES); end
            cyc++;
        end
        in_valid = 1'b0;
        checks++; if (k != n) begin errors++; $display("FAIL load_timeout: accepted %0d want %0d", k, n); end
    endtask

    task automatic test_load(input bit gaps);
        do_load(NBYTES, gaps);
        checks++; if (bfr[TOT-1 -: 8] !== 8'h00 || bfr[7:0] !== 8'(NBYTES - 1)) begin errors++; $display("FAIL load_ends: got msb %h lsb %h want 00 %h", bfr[TOT-1 -: 8], bfr[7:0], 8'(NBYTES - 1)); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL load_in_ready: got %b want 0", in_ready); end
    endtask

    task automatic test_capture();
        logic [TOT-1:0] b;
        data_core = rnd_blk();
        cap_st = 1'b1; cap_tk = 1'b1; start_rd = 1'b1;
        step();
        cap_st = 1'b0; cap_tk = 1'b0; start_rd = 1'b0;
        mdl = data_core;
        checks++; if (bfr !== mdl) begin errors++; $display("FAIL cap_both: got %h want %h", bfr, mdl); end
        checks++; if (full !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL cap_wins: full=%b out_valid=%b want 1 0", full, out_valid); end
        b = rnd_blk();
        data_core = b; cap_tk = 1'b1;
        step();
        cap_tk = 1'b0;
        mdl[ST_LO-1:0] = b[ST_LO-1:0];
        checks++; if (bfr !== mdl) begin errors++; $display("FAIL cap_tk_only: got %h want %h", bfr, mdl); end
        b = rnd_blk();
        data_core = b; cap_st = 1'b1;
        step();
        cap_st = 1'b0;
        mdl[TOT-1:ST_LO] = b[TOT-1:ST_LO];
        checks++; if (bfr !== mdl) begin errors++; $display("FAIL cap_st_only: got %h want %h", bfr, mdl); end
        in_valid = 1'b1; in_data = 8'h5A;
        step();
        in_valid = 1'b0;
        checks++; if (bfr !== mdl || full !== 1'b1) begin errors++; $display("FAIL full_ignores_in: full=%b bfr_lsb=%h want 1 %h", full, bfr[7:0], mdl[7:0]); end
    endtask

    task automatic test_unload();
        logic [7:0] q[$];
        logic [7:0] prev, exp_b;
        int cyc = 0;
        for (int i = 0; i < OUT_BYTES; i++) q.push_back(mdl[TOT-1-8*i -: 8]);
        start_rd = 1'b1;
        step();
        start_rd = 1'b0;
        checks++; if (out_valid !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL unload_start: out_valid=%b full=%b want 1 0", out_valid, full); end
        while (q.size() > 0 && cyc < 4 * OUT_BYTES) begin
            out_ready = (cyc % 2 == 0);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL unload_valid at cycle %0d: got %b want 1", cyc, out_valid); end
            if (out_ready) begin
                exp_b = q.pop_front();
                checks++; if (out_data !== exp_b) begin errors++; $display("FAIL unload_byte %0d: got %h want %h", OUT_BYTES - 1 - q.size(), out_data, exp_b); end
            end
            prev = out_data;
            step();
            if (!out_ready) begin
                checks++; if (out_data !== prev) begin errors++; $display("FAIL unload_stall: got %h want %h", out_data, prev); end
            end
            cyc++;
        end
        out_ready = 1'b0;
        mdl = mdl << (8 * OUT_BYTES);
        checks++; if (q.size() != 0) begin errors++; $display("FAIL unload_timeout: %0d bytes left want 0", q.size()); end
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL unload_end: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid); end
        checks++; if (bfr !== mdl) begin errors++; $display("FAIL unload_residue: got %h want %h", bfr, mdl); end
    endtask

    task automatic test_ignored();
        data_core = rnd_blk();
        cap_st = 1'b1; cap_tk = 1'b1; start_rd = 1'b1;
        step();
        cap_st = 1'b0; cap_tk = 1'b0; start_rd = 1'b0;
        checks++; if (bfr !== mdl || in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL empty_ignores: in_ready=%b out_valid=%b bfr_match=%b want 1 0 1", in_ready, out_valid, bfr === mdl); end
    endtask

    task automatic test_clr();
        do_load(50, 1'b0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        mdl = '0;
        checks++; if (bfr !== '0 || in_ready !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL clr_load: bfr_nonzero=%b in_ready=%b full=%b want 0 1 0", bfr != '0, in_ready, full); end
        do_load(NBYTES, 1'b0);
        start_rd = 1'b1;
        step();
        start_rd = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        out_ready = 1'b0;
        mdl = '0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || bfr !== '0) begin errors++; $display("FAIL clr_unload: out_valid=%b in_ready=%b bfr_nonzero=%b want 0 1 0", out_valid, in_ready, bfr != '0); end
    endtask

    task automatic test_async_rst();
        do_load(NBYTES, 1'b1);
        start_rd = 1'b1;
        step();
        start_rd = 1'b0;
        out_ready = 1'b1;
        repeat (2) step();
        out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || full !== 1'b0 || bfr !== '0 || in_ready !== 1'b1) begin errors++; $display("FAIL async_rst: out_valid=%b full=%b bfr_nonzero=%b in_ready=%b want 0 0 0 1", out_valid, full, bfr != '0, in_ready); end
        #1 rst = 1'b0;
        mdl = '0;
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        data_core = '0; cap_st = 1'b0; cap_tk = 1'b0; start_rd = 1'b0; clr = 1'b0;
        mdl = '0;
        test_reset();
        test_load(1'b0);
        test_capture();
        test_unload();
        test_ignored();
        test_load(1'b1);
        test_unload();
        test_clr();
        test_async_rst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
